// File: rtl/mem_port_arbiter_if.sv
// Requester and memory-side signal bundle for mem_port_arbiter.
// slave is the arbiter's view; master is the requester/memory side.
interface mem_port_arbiter_if;
  logic        req0;
  logic [31:0] addr0;
  logic        gnt0;
  logic        rvalid0;
  logic [31:0] rdata0;

  logic        req1;
  logic [31:0] addr1;
  logic        we1;
  logic [31:0] wdata1;
  logic [1:0]  size1;
  logic        unsigned1;
  logic        gnt1;
  logic        rvalid1;
  logic [31:0] rdata1;

  logic [31:0] mem_address;
  logic        mem_read_write;
  logic [31:0] mem_data_in;
  logic [1:0]  mem_access_size;
  logic [31:0] mem_data_out;

  modport slave (
    input  req0, addr0,
    input  req1, addr1, we1, wdata1, size1, unsigned1,
    input  mem_data_out,
    output gnt0, rvalid0, rdata0,
    output gnt1, rvalid1, rdata1,
    output mem_address, mem_read_write, mem_data_in, mem_access_size
  );

  modport master (
    output req0, addr0,
    output req1, addr1, we1, wdata1, size1, unsigned1,
    output mem_data_out,
    input  gnt0, rvalid0, rdata0,
    input  gnt1, rvalid1, rdata1,
    input  mem_address, mem_read_write, mem_data_in, mem_access_size
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-port round-robin arbiter for a single data-memory port with
// programmable wait states and load-data formatting.
//
// state  | meaning
// IDLE   | arbitrating; gnt may assert, pending rvalid is presented here
// ACCESS | latched request driven to memory for WAIT_STATES+1 cycles
module mem_port_arbiter #(
  parameter int WAIT_STATES = 0,
  parameter int CNT_W       = 4
) (
  input logic               clock,
  input logic               reset_n,
  mem_port_arbiter_if.slave bus
);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic               last_grant;
  logic [31:0]        addr_q;
  logic               we_q;
  logic [31:0]        wdata_q;
  logic [1:0]         size_q;
  logic               uns_q;
  logic               owner_q;
  logic               mrw_q;
  logic [31:0]        rdata0_q;
  logic [31:0]        rdata1_q;
  logic               rvalid0_q;
  logic               rvalid1_q;

  logic               gnt0_w;
  logic               gnt1_w;
  logic [31:0]        load_data;

  function automatic logic [31:0] format_load(input logic [31:0] word,
                                              input logic [1:0]  size,
                                              input logic        uns);
    logic [31:0] res;
    case (size)
      2'd0:    res = {{24{~uns & word[7]}},  word[7:0]};
      2'd1:    res = {{16{~uns & word[15]}}, word[15:0]};
      default: res = word;
    endcase
    return res;
  endfunction

  // On a tie the port that did not win last time is served.
  assign gnt0_w = (state == IDLE) && bus.req0 && (!bus.req1 || last_grant);
  assign gnt1_w = (state == IDLE) && bus.req1 && (!bus.req0 || !last_grant);

  assign load_data = format_load(bus.mem_data_out, size_q, uns_q);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      cnt        <= '0;
      last_grant <= 1'b1;
      addr_q     <= '0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      size_q     <= 2'd2;
      uns_q      <= 1'b0;
      owner_q    <= 1'b0;
      mrw_q      <= 1'b0;
      rdata0_q   <= '0;
      rdata1_q   <= '0;
      rvalid0_q  <= 1'b0;
      rvalid1_q  <= 1'b0;
    end else begin
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      case (state)
        IDLE: begin
          if (gnt1_w) begin
            addr_q     <= bus.addr1;
            we_q       <= bus.we1;
            wdata_q    <= bus.wdata1;
            size_q     <= bus.size1;
            uns_q      <= bus.unsigned1;
            owner_q    <= 1'b1;
            last_grant <= 1'b1;
            mrw_q      <= (WAIT_STATES == 0) && bus.we1;
            cnt        <= CNT_W'(WAIT_STATES);
            state      <= ACCESS;
          end else if (gnt0_w) begin
            addr_q     <= bus.addr0;
            we_q       <= 1'b0;
            size_q     <= 2'd2;
            uns_q      <= 1'b0;
            owner_q    <= 1'b0;
            last_grant <= 1'b0;
            mrw_q      <= 1'b0;
            cnt        <= CNT_W'(WAIT_STATES);
            state      <= ACCESS;
          end
        end
        ACCESS: begin
          if (cnt == '0) begin
            if (owner_q) begin
              rdata1_q  <= we_q ? 32'd0 : load_data;
              rvalid1_q <= 1'b1;
            end else begin
              rdata0_q  <= we_q ? 32'd0 : load_data;
              rvalid0_q <= 1'b1;
            end
            mrw_q <= 1'b0;
            state <= IDLE;
          end else begin
            cnt <= cnt - 1'b1;
            // Write strobe is pre-registered so it lands on the terminal cycle only.
            if (cnt == CNT_W'(1)) mrw_q <= we_q;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.gnt0            = gnt0_w;
  assign bus.gnt1            = gnt1_w;
  assign bus.rvalid0         = rvalid0_q;
  assign bus.rvalid1         = rvalid1_q;
  assign bus.rdata0          = rdata0_q;
  assign bus.rdata1          = rdata1_q;
  assign bus.mem_address     = addr_q;
  assign bus.mem_read_write  = mrw_q;
  assign bus.mem_data_in     = wdata_q;
  assign bus.mem_access_size = size_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: one instance with no wait states,
// one with two, sharing stimulus and a little-endian byte memory model.
module tb_mem_port_arbiter;

  typedef struct packed {
    logic        port;
    logic [31:0] data;
  } exp_t;

  logic        clock;
  logic        rst_a, rst_b, sel;
  logic        req0, req1, we1, uns1;
  logic [31:0] addr0, addr1, wdata1;
  logic [1:0]  size1;
  logic [7:0]  mem [0:1023];
  int          cyc = 0;
  int          n_tests = 0;
  int          n_fail = 0;
  exp_t        sb_q[$];

  mem_port_arbiter_if ifa();
  mem_port_arbiter_if ifb();

  mem_port_arbiter #(.WAIT_STATES(0), .CNT_W(4)) dut_a (
    .clock(clock), .reset_n(rst_a), .bus(ifa.slave));
  mem_port_arbiter #(.WAIT_STATES(2), .CNT_W(4)) dut_b (
    .clock(clock), .reset_n(rst_b), .bus(ifb.slave));

  assign ifa.req0 = req0;  assign ifb.req0 = req0;
  assign ifa.addr0 = addr0; assign ifb.addr0 = addr0;
  assign ifa.req1 = req1;  assign ifb.req1 = req1;
  assign ifa.addr1 = addr1; assign ifb.addr1 = addr1;
  assign ifa.we1 = we1;    assign ifb.we1 = we1;
  assign ifa.wdata1 = wdata1; assign ifb.wdata1 = wdata1;
  assign ifa.size1 = size1; assign ifb.size1 = size1;
  assign ifa.unsigned1 = uns1; assign ifb.unsigned1 = uns1;

  assign ifa.mem_data_out = {mem[ifa.mem_address[9:0] + 10'd3], mem[ifa.mem_address[9:0] + 10'd2],
                             mem[ifa.mem_address[9:0] + 10'd1], mem[ifa.mem_address[9:0]]};
  assign ifb.mem_data_out = {mem[ifb.mem_address[9:0] + 10'd3], mem[ifb.mem_address[9:0] + 10'd2],
                             mem[ifb.mem_address[9:0] + 10'd1], mem[ifb.mem_address[9:0]]};

  wire        g0     = sel ? ifb.gnt0 : ifa.gnt0;
  wire        g1     = sel ? ifb.gnt1 : ifa.gnt1;
  wire        rv0    = sel ? ifb.rvalid0 : ifa.rvalid0;
  wire        rv1    = sel ? ifb.rvalid1 : ifa.rvalid1;
  wire [31:0] rd0    = sel ? ifb.rdata0 : ifa.rdata0;
  wire [31:0] rd1    = sel ? ifb.rdata1 : ifa.rdata1;
  wire [31:0] m_addr = sel ? ifb.mem_address : ifa.mem_address;
  wire        m_rw   = sel ? ifb.mem_read_write : ifa.mem_read_write;
  wire [31:0] m_din  = sel ? ifb.mem_data_in : ifa.mem_data_in;
  wire [1:0]  m_size = sel ? ifb.mem_access_size : ifa.mem_access_size;

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  always @(posedge clock) cyc <= cyc + 1;

  always @(posedge clock) begin
    if (m_rw) begin
      mem[m_addr[9:0]] <= m_din[7:0];
      if (m_size != 2'd0) mem[m_addr[9:0] + 10'd1] <= m_din[15:8];
      if (m_size[1]) begin
        mem[m_addr[9:0] + 10'd2] <= m_din[23:16];
        mem[m_addr[9:0] + 10'd3] <= m_din[31:24];
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1, "watchdog");
  end

  task automatic issue(input logic port, input logic [31:0] addr, input logic we,
                       input logic [31:0] wd, input logic [1:0] sz, input logic un,
                       input logic [31:0] exp, output int gcyc, output bit ok);
    exp_t e;
    @(posedge clock); #1;
    if (port) begin
      req1 = 1'b1; addr1 = addr; we1 = we; wdata1 = wd; size1 = sz; uns1 = un;
    end else begin
      req0 = 1'b1; addr0 = addr;
    end
    ok = 1'b0;
    gcyc = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if ((port ? g1 : g0) === 1'b1) begin
        ok = 1'b1;
        gcyc = cyc;
        break;
      end
    end
    if (ok) begin
      e.port = port;
      e.data = exp;
      sb_q.push_back(e);
    end
    @(posedge clock); #1;
    req0 = 1'b0;
    req1 = 1'b0;
  endtask

  task automatic wait_rv(output int rcyc, output logic port, output logic [31:0] data,
                         output bit ok);
    ok = 1'b0;
    rcyc = -1;
    port = 1'b0;
    data = '0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (rv0 === 1'b1 || rv1 === 1'b1) begin
        ok = 1'b1;
        rcyc = cyc;
        port = rv1;
        data = rv1 ? rd1 : rd0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clock);
    n_tests++;
    if ({g0, g1, rv0, rv1} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_handshake: got %b expected 0000", {g0, g1, rv0, rv1});
    end
    n_tests++;
    if (rd0 !== 32'd0 || rd1 !== 32'd0) begin
      n_fail++; $display("FAIL reset_rdata: got %h/%h expected 0/0", rd0, rd1);
    end
    n_tests++;
    if (m_rw !== 1'b0 || m_addr !== 32'd0 || m_din !== 32'd0 || m_size !== 2'd2) begin
      n_fail++;
      $display("FAIL reset_mem: got rw=%b addr=%h din=%h size=%0d expected 0/0/0/2",
               m_rw, m_addr, m_din, m_size);
    end
  endtask

  task automatic test_write_ws0();
    int gcyc, rcyc;
    bit ok;
    logic p;
    logic [31:0] d;
    exp_t e;
    issue(1'b1, 32'h100, 1'b1, 32'hDEADBEEF, 2'd2, 1'b0, 32'd0, gcyc, ok);
    n_tests++;
    if (!ok) begin n_fail++; $display("FAIL ws0_gnt1: got timeout expected grant"); end
    @(negedge clock);
    n_tests++;
    if (m_rw !== 1'b1 || m_addr !== 32'h100 || m_din !== 32'hDEADBEEF || rv1 !== 1'b0) begin
      n_fail++;
      $display("FAIL ws0_write_cycle: got rw=%b addr=%h din=%h rv1=%b expected 1/100/deadbeef/0",
               m_rw, m_addr, m_din, rv1);
    end
    wait_rv(rcyc, p, d, ok);
    n_tests++;
    if (!ok || rcyc !== gcyc + 2 || m_rw !== 1'b0) begin
      n_fail++;
      $display("FAIL ws0_write_latency: got cycle %0d rw=%b expected cycle %0d rw=0",
               rcyc - gcyc, m_rw, 2);
    end
    n_tests++;
    if (sb_q.size() == 0) begin
      n_fail++; $display("FAIL ws0_write_sb: got empty scoreboard expected entry");
    end else begin
      e = sb_q.pop_front();
      if (p !== e.port || d !== e.data) begin
        n_fail++;
        $display("FAIL ws0_write_resp: got port %b data %h expected port %b data %h", p, d, e.port, e.data);
      end
    end
  endtask

  task automatic test_load_format();
    logic        ports [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    logic [31:0] addrs [4] = '{32'h103, 32'h103, 32'h100, 32'h100};
    logic [1:0]  sizes [4] = '{2'd0, 2'd0, 2'd1, 2'd2};
    logic        unss  [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    logic [31:0] exps  [4] = '{32'hFFFFFFDE, 32'h000000DE, 32'hFFFFBEEF, 32'hDEADBEEF};
    int gcyc, rcyc;
    bit ok;
    logic p;
    logic [31:0] d;
    exp_t e;
    for (int k = 0; k < 4; k++) begin
      issue(ports[k], addrs[k], 1'b0, 32'h0, sizes[k], unss[k], exps[k], gcyc, ok);
      wait_rv(rcyc, p, d, ok);
      n_tests++;
      if (!ok || rcyc !== gcyc + 2) begin
        n_fail++; $display("FAIL load_latency_%0d: got %0d expected 2", k, rcyc - gcyc);
      end
      n_tests++;
      if (sb_q.size() == 0) begin
        n_fail++; $display("FAIL load_sb_%0d: got empty scoreboard expected entry", k);
      end else begin
        e = sb_q.pop_front();
        if (p !== e.port || d !== e.data) begin
          n_fail++;
          $display("FAIL load_%0d: got port %b data %h expected port %b data %h", k, p, d, e.port, e.data);
        end
      end
    end
  endtask

  task automatic test_round_robin();
    int start, ngr;
    exp_t e;
    @(posedge clock); #1;
    rst_a = 1'b0;
    req0 = 1'b1; addr0 = 32'h100;
    req1 = 1'b1; addr1 = 32'h100; we1 = 1'b0; size1 = 2'd2; uns1 = 1'b0;
    @(posedge clock); #1;
    rst_a = 1'b1;
    start = cyc;
    ngr = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clock);
      if (rv0 === 1'b1 || rv1 === 1'b1) begin
        n_tests++;
        if (sb_q.size() == 0) begin
          n_fail++; $display("FAIL rr_sb: got unexpected rvalid expected none");
        end else begin
          e = sb_q.pop_front();
          if (rv1 !== e.port || (rv1 ? rd1 : rd0) !== e.data) begin
            n_fail++;
            $display("FAIL rr_resp: got port %b data %h expected port %b data %h",
                     rv1, rv1 ? rd1 : rd0, e.port, e.data);
          end
        end
      end
      if (g0 === 1'b1 && g1 === 1'b1) begin
        n_tests++; n_fail++;
        $display("FAIL rr_double_gnt: got both grants expected one");
      end else if (g0 === 1'b1 || g1 === 1'b1) begin
        n_tests++;
        if (g1 !== ngr[0] || cyc !== start + 2 * ngr) begin
          n_fail++;
          $display("FAIL rr_grant_%0d: got port %b at +%0d expected port %b at +%0d",
                   ngr, g1, cyc - start, ngr[0], 2 * ngr);
        end
        e.port = g1;
        e.data = 32'hDEADBEEF;
        sb_q.push_back(e);
        ngr++;
      end
    end
    @(posedge clock); #1;
    req0 = 1'b0;
    req1 = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      if ((rv0 === 1'b1 || rv1 === 1'b1) && sb_q.size() != 0) begin
        e = sb_q.pop_front();
        n_tests++;
        if (rv1 !== e.port || (rv1 ? rd1 : rd0) !== e.data) begin
          n_fail++;
          $display("FAIL rr_drain: got port %b data %h expected port %b data %h",
                   rv1, rv1 ? rd1 : rd0, e.port, e.data);
        end
      end
    end
    n_tests++;
    if (ngr !== 6 || sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL rr_count: got %0d grants %0d pending expected 6 grants 0 pending", ngr, sb_q.size());
    end
  endtask

  task automatic test_wait_states();
    int gcyc, rcyc;
    bit ok;
    logic p;
    logic [31:0] d;
    exp_t e;
    @(posedge clock); #1;
    rst_a = 1'b0;
    sel = 1'b1;
    rst_b = 1'b1;
    issue(1'b1, 32'h200, 1'b1, 32'h12345678, 2'd2, 1'b0, 32'd0, gcyc, ok);
    addr1 = 32'h300; wdata1 = 32'hCAFEF00D; size1 = 2'd0;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clock);
      n_tests++;
      if (!ok || m_addr !== 32'h200 || m_din !== 32'h12345678 || m_rw !== (k == 3) || rv1 !== 1'b0) begin
        n_fail++;
        $display("FAIL ws2_access_%0d: got addr=%h din=%h rw=%b rv1=%b expected 200/12345678/%b/0",
                 k, m_addr, m_din, m_rw, rv1, (k == 3));
      end
    end
    wait_rv(rcyc, p, d, ok);
    n_tests++;
    if (!ok || rcyc !== gcyc + 4) begin
      n_fail++; $display("FAIL ws2_write_latency: got %0d expected 4", rcyc - gcyc);
    end
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      n_tests++;
      if (p !== e.port || d !== e.data) begin
        n_fail++;
        $display("FAIL ws2_write_resp: got port %b data %h expected port %b data %h", p, d, e.port, e.data);
      end
    end
    issue(1'b0, 32'h200, 1'b0, 32'h0, 2'd2, 1'b0, 32'h12345678, gcyc, ok);
    wait_rv(rcyc, p, d, ok);
    n_tests++;
    if (!ok || rcyc !== gcyc + 4 || sb_q.size() == 0) begin
      n_fail++; $display("FAIL ws2_read_latency: got %0d expected 4", rcyc - gcyc);
    end else begin
      e = sb_q.pop_front();
      n_tests++;
      if (p !== e.port || d !== e.data) begin
        n_fail++;
        $display("FAIL ws2_read_resp: got port %b data %h expected port %b data %h", p, d, e.port, e.data);
      end
    end
    n_tests++;
    if (mem[10'h300] !== 8'h00) begin
      n_fail++; $display("FAIL ws2_late_addr: got mem[300]=%h expected 00", mem[10'h300]);
    end
  endtask

  task automatic test_reset_mid_access();
    int gcyc, rcyc;
    bit ok;
    logic p;
    logic [31:0] d;
    exp_t e;
    issue(1'b1, 32'h400, 1'b1, 32'hA5A5A5A5, 2'd2, 1'b0, 32'd0, gcyc, ok);
    if (sb_q.size() != 0) e = sb_q.pop_back();
    rst_b = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      n_tests++;
      if (m_rw !== 1'b0 || rv0 !== 1'b0 || rv1 !== 1'b0) begin
        n_fail++;
        $display("FAIL abort_%0d: got rw=%b rv=%b%b expected 0/00", k, m_rw, rv0, rv1);
      end
    end
    @(posedge clock); #1;
    rst_b = 1'b1;
    req0 = 1'b1; addr0 = 32'h400;
    req1 = 1'b1; addr1 = 32'h404; we1 = 1'b0; size1 = 2'd2;
    @(negedge clock);
    gcyc = cyc;
    n_tests++;
    if (g0 !== 1'b1 || g1 !== 1'b0) begin
      n_fail++; $display("FAIL abort_tie: got gnt0=%b gnt1=%b expected 1/0", g0, g1);
    end
    e.port = 1'b0;
    e.data = 32'h0;
    sb_q.push_back(e);
    @(posedge clock); #1;
    req0 = 1'b0;
    req1 = 1'b0;
    wait_rv(rcyc, p, d, ok);
    n_tests++;
    if (!ok || rcyc !== gcyc + 4) begin
      n_fail++; $display("FAIL abort_read_latency: got %0d expected 4", rcyc - gcyc);
    end
    e = sb_q.pop_front();
    n_tests++;
    if (p !== e.port || d !== e.data) begin
      n_fail++;
      $display("FAIL abort_no_write: got port %b data %h expected port %b data %h", p, d, e.port, e.data);
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
    sel = 1'b0;
    rst_a = 1'b0;
    rst_b = 1'b0;
    req0 = 1'b0; addr0 = '0;
    req1 = 1'b0; addr1 = '0; we1 = 1'b0; wdata1 = '0; size1 = 2'd2; uns1 = 1'b0;
    repeat (2) @(posedge clock);
    test_reset();
    @(posedge clock); #1;
    rst_a = 1'b1;
    test_write_ws0();
    test_load_format();
    test_round_robin();
    test_wait_states();
    test_reset_mid_access();
    repeat (2) @(posedge clock);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
